// File: rtl/usrt_pkg.sv
// usrt_pkg: constants and types shared across the USRT transmit path.
package usrt_pkg;
   localparam int FRAME_W    = 11;
   localparam int START_BIT  = 0;
   localparam int DATA_LSB   = 1;
   localparam int DATA_MSB   = 8;
   localparam int PARITY_BIT = 9;
   localparam int STOP_BIT   = 10;
   typedef enum logic [1:0] {PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_e;
   typedef enum logic {IDLE, SHIFT} tx_state_e;
endpackage

// File: rtl/usrt_tx_shifter_if.sv
// usrt_tx_shifter_if: frame handshake and serial line bundle of the transmit shifter.
interface usrt_tx_shifter_if;
   import usrt_pkg::*;
   logic [FRAME_W-1:0] i_Data;
   logic               i_Valid;
   logic               o_Ready;
   logic               o_Txd;
   logic               o_Sclk;
   logic               o_Busy;
   logic               o_Done;
   modport master (output i_Data, i_Valid, input o_Ready, o_Txd, o_Sclk, o_Busy, o_Done);
   modport slave  (input i_Data, i_Valid, output o_Ready, o_Txd, o_Sclk, o_Busy, o_Done);
endinterface

// File: rtl/usrt_bit_timer.sv
// usrt_bit_timer: per-bit clock counter generating the serial clock and bit-end strobes.
module usrt_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic sclk,
   output logic bit_end,
   output logic near_end
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   logic [CW-1:0] ccnt, nxt;
   assign nxt      = (ccnt == LAST) ? '0 : ccnt + 1'b1;
   assign bit_end  = en && ccnt == LAST;
   assign near_end = en && ccnt == PRE;
   // sclk is registered from the next count so it rises exactly at mid-bit
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         ccnt <= '0;
         sclk <= 1'b0;
      end else begin
         ccnt <= nxt;
         sclk <= nxt >= HALF;
      end
   end
endmodule

// File: rtl/usrt_tx_shifter.sv
// usrt_tx_shifter: LSB-first frame serializer with synchronous serial clock.
// Define TX_HOLD_BUFFER_EN for a one-entry holding register giving gapless back-to-back frames.
module usrt_tx_shifter
   import usrt_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input logic              i_Pclk,
   input logic              i_Rst,
   usrt_tx_shifter_if.slave bus
);
   localparam int BW = $clog2(FRAME_W);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
   tx_state_e          state;
   logic [FRAME_W-1:0] sr, shifted;
   logic [BW-1:0]      bcnt;
   logic               ready, busy, done, bit_end, near_end, xfer, last;
`ifdef TX_HOLD_BUFFER_EN
   logic [FRAME_W-1:0] hold;
   logic               hold_full;
`endif
   assign xfer    = bus.i_Valid && ready;
   assign last    = bit_end && bcnt == LAST_BIT;
   // shifting in ones leaves the line idle-high once the frame has drained
   assign shifted = {1'b1, sr[FRAME_W-1:1]};
   usrt_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk      (i_Pclk),
      .rst      (i_Rst),
      .en       (busy),
      .sclk     (bus.o_Sclk),
      .bit_end  (bit_end),
      .near_end (near_end)
   );
   always_ff @(posedge i_Pclk) begin
      if (i_Rst) begin
         state <= IDLE;
         sr    <= '1;
         bcnt  <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef TX_HOLD_BUFFER_EN
         hold      <= '0;
         hold_full <= 1'b0;
`endif
      end else begin
         done <= near_end && bcnt == LAST_BIT;
`ifdef TX_HOLD_BUFFER_EN
         if (state == IDLE || last) begin
            if (hold_full) begin
               sr        <= hold;
               hold_full <= 1'b0;
               ready     <= 1'b1;
               state     <= SHIFT;
               busy      <= 1'b1;
               bcnt      <= '0;
            end else if (xfer) begin
               sr    <= bus.i_Data;
               state <= SHIFT;
               busy  <= 1'b1;
               bcnt  <= '0;
            end else if (last) begin
               sr    <= shifted;
               state <= IDLE;
               busy  <= 1'b0;
               bcnt  <= '0;
            end
         end else begin
            if (bit_end) begin
               sr   <= shifted;
               bcnt <= bcnt + 1'b1;
            end
            if (xfer) begin
               hold      <= bus.i_Data;
               hold_full <= 1'b1;
               ready     <= 1'b0;
            end
         end
`else
         if (state == IDLE) begin
            if (xfer) begin
               sr    <= bus.i_Data;
               state <= SHIFT;
               busy  <= 1'b1;
               ready <= 1'b0;
               bcnt  <= '0;
            end
         end else if (bit_end) begin
            sr   <= shifted;
            bcnt <= last ? '0 : bcnt + 1'b1;
            if (last) begin
               state <= IDLE;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         end
`endif
      end
   end
   assign bus.o_Ready = ready;
   assign bus.o_Txd   = sr[0];
   assign bus.o_Busy  = busy;
   assign bus.o_Done  = done;
endmodule

// File: tb/tb_usrt_tx_shifter.sv
// tb_usrt_tx_shifter: randomized self-checking bench against a cycle-indexed frame model.
module tb_usrt_tx_shifter;
   localparam int FW  = 11;
   localparam int CPB = 4;
   localparam int FL  = FW * CPB;
`ifdef TX_HOLD_BUFFER_EN
   localparam logic HOLD = 1'b1;
`else
   localparam logic HOLD = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   passed = 0;
   always #5 clk = ~clk;
   usrt_tx_shifter_if bus();
   usrt_tx_shifter #(.CLKS_PER_BIT(CPB)) dut (.i_Pclk(clk), .i_Rst(rst), .bus(bus));
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset;
      bus.i_Valid = 1'b0;
      bus.i_Data  = 11'($urandom);
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if ({bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done} !== 5'b10100)
         $display("FAIL reset txd/sclk/ready/busy/done got %b want 10100", {bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done});
      else passed++;
      rst = 1'b0;
   endtask
   task automatic test_idle;
      int bad = 0;
      bus.i_Data = '0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if ({bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done} !== 5'b10100) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL idle_hold changed cycles got %0d want 0", bad);
      else passed++;
   endtask
   task automatic send_frame(input logic [10:0] f, input string tag);
      int   w = 0;
      int   rises = 0;
      logic prev = 1'b0;
      bus.i_Data  = f;
      bus.i_Valid = 1'b1;
      while (!bus.o_Ready && w < 200) begin
         tick();
         w++;
      end
      checks++;
      if (!bus.o_Ready) $display("FAIL %s accept timeout ready got 0 want 1", tag);
      else passed++;
      tick();
      bus.i_Valid = 1'b0;
      bus.i_Data  = 11'($urandom);
      for (int n = 1; n <= FL; n++) begin
         logic et, es, ed;
         et = f[(n-1)/CPB];
         es = ((n - 1) % CPB) >= CPB / 2;
         ed = (n == FL);
         checks++;
         if ({bus.o_Txd, bus.o_Sclk, bus.o_Done, bus.o_Busy, bus.o_Ready} !== {et, es, ed, 1'b1, HOLD})
            $display("FAIL %s cycle %0d txd/sclk/done/busy/ready got %b want %b", tag, n,
                     {bus.o_Txd, bus.o_Sclk, bus.o_Done, bus.o_Busy, bus.o_Ready}, {et, es, ed, 1'b1, HOLD});
         else passed++;
         if (bus.o_Sclk && !prev) rises++;
         prev = bus.o_Sclk;
         tick();
      end
      checks++;
      if ({bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done} !== 5'b10100)
         $display("FAIL %s post_frame txd/sclk/ready/busy/done got %b want 10100", tag, {bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done});
      else passed++;
      checks++;
      if (rises != FW) $display("FAIL %s sclk_rises got %0d want %0d", tag, rises, FW);
      else passed++;
   endtask
   task automatic test_random_frames;
      for (int i = 0; i < 4; i++) begin
         logic [10:0] f;
         f = (11'($urandom) & 11'h3FE) | 11'h400;
         send_frame(f, $sformatf("rand%0d", i));
         repeat ($urandom_range(0, 5)) tick();
      end
   endtask
   task automatic test_back_to_back;
      logic [10:0] f1, f2;
      int acc2 = -1;
      int w = 0;
      int g;
      g  = HOLD ? 0 : 1;
      f1 = 11'($urandom) & 11'h7FE;
      f2 = 11'($urandom) & 11'h7FE;
      bus.i_Data  = f1;
      bus.i_Valid = 1'b1;
      while (!bus.o_Ready && w < 200) begin
         tick();
         w++;
      end
      tick();
      bus.i_Data = f2;
      for (int n = 1; n <= 2 * FL + g + 3; n++) begin
         logic e, ed;
         e  = (n <= FL) ? f1[(n-1)/CPB] : (n >= FL + 1 + g && n <= 2 * FL + g) ? f2[(n-1-FL-g)/CPB] : 1'b1;
         ed = (n == FL) || (n == 2 * FL + g);
         checks++;
         if ({bus.o_Txd, bus.o_Done} !== {e, ed})
            $display("FAIL b2b cycle %0d txd/done got %b want %b", n, {bus.o_Txd, bus.o_Done}, {e, ed});
         else passed++;
         if (acc2 < 0 && bus.i_Valid && bus.o_Ready) acc2 = n;
         tick();
         if (acc2 > 0) bus.i_Valid = 1'b0;
      end
      bus.i_Valid = 1'b0;
      checks++;
      if (acc2 != (HOLD ? 1 : FL + 1)) $display("FAIL b2b second_accept_edge got %0d want %0d", acc2, HOLD ? 1 : FL + 1);
      else passed++;
   endtask
   task automatic test_abort;
      int w = 0;
      int early_done = 0;
      int bad = 0;
      bus.i_Data  = 11'h406;
      bus.i_Valid = 1'b1;
      while (!bus.o_Ready && w < 200) begin
         tick();
         w++;
      end
      tick();
      bus.i_Data = 11'($urandom) & 11'h7FE;
      for (int n = 1; n < 22; n++) begin
         if (bus.o_Done) early_done++;
         tick();
         bus.i_Valid = 1'b0;
      end
      checks++;
      if (bus.o_Txd !== 1'b0 || early_done != 0)
         $display("FAIL abort bit5 txd/early_done got %b/%0d want 0/0", bus.o_Txd, early_done);
      else passed++;
      rst = 1'b1;
      tick();
      checks++;
      if ({bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done} !== 5'b10100)
         $display("FAIL abort reset_edge txd/sclk/ready/busy/done got %b want 10100", {bus.o_Txd, bus.o_Sclk, bus.o_Ready, bus.o_Busy, bus.o_Done});
      else passed++;
      rst = 1'b0;
      for (int n = 0; n < 60; n++) begin
         tick();
         if (bus.o_Txd !== 1'b1 || bus.o_Done !== 1'b0 || bus.o_Busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) $display("FAIL abort aftermath bad_cycles got %0d want 0", bad);
      else passed++;
   endtask
   task automatic test_ignore_invalid;
      bus.i_Valid = 1'b0;
      for (int n = 0; n < 30; n++) begin
         bus.i_Data = 11'($urandom) & 11'h7FE;
         tick();
         checks++;
         if ({bus.o_Txd, bus.o_Busy, bus.o_Ready} !== 3'b101)
            $display("FAIL invalid_ignored cycle %0d txd/busy/ready got %b want 101", n, {bus.o_Txd, bus.o_Busy, bus.o_Ready});
         else passed++;
      end
   endtask
   initial begin
      test_reset();
      test_idle();
      send_frame(11'h406, "frame_406");
      send_frame(11'h60E, "frame_60E");
      test_random_frames();
      test_back_to_back();
      test_abort();
      test_ignore_invalid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
